mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access (MEM) stage of the filter processor pipeline, sitting between the EX/MEM pipeline register and Register_MEM_WB. It performs loads and stores over a req/ack data-memory port, passes ALU results through for non-memory instructions, and stalls upstream stages while a memory access is outstanding. Its registered outputs drive Register_MEM_WB's i_WE_MEM_WB, i_WB_Data and i_WB_Dir inputs directly.

## Interface
- DATA_W, 32, data and address width
- DIR_W, 4, register-file address width
- TIMEOUT, 16, cycles in BUSY without ack before the access is aborted (2..255)

Ports:
- clk  in  1  single clock; every flop is rising-edge
- rst  in  1  asynchronous, active-high reset
- i_valid  in  1  an instruction is presented by EX/MEM this cycle
- i_mem_read  in  1  instruction is a load
- i_mem_write  in  1  instruction is a store; i_mem_read and i_mem_write both high is illegal
- i_addr  in  DATA_W  memory address
- i_store_data  in  DATA_W  store data
- i_alu_result  in  DATA_W  result for non-memory instructions
- i_WE  in  1  instruction writes the register file
- i_WB_Dir  in  DIR_W  destination register
- o_stall  out  1  upstream must hold its current instruction
- o_mem_req  out  1  memory request
- o_mem_we  out  1  1 = write, 0 = read
- o_mem_addr  out  DATA_W  request address
- o_mem_wdata  out  DATA_W  write data
- i_mem_ack  in  1  request completed; i_mem_rdata valid in the same cycle
- i_mem_rdata  in  DATA_W  read data
- o_WE_MEM_WB  out  1  to Register_MEM_WB i_WE_MEM_WB
- o_WB_Data  out  DATA_W  to Register_MEM_WB i_WB_Data
- o_WB_Dir  out  DIR_W  to Register_MEM_WB i_WB_Dir
- o_mem_err  out  1  sticky flag set on timeout; cleared only by rst

## Operation
- States: IDLE and BUSY.
- IDLE, i_valid=0: o_WE_MEM_WB is registered as 0, which inserts a bubble.
- IDLE, i_valid=1, no memory op: register o_WB_Data=i_alu_result, o_WB_Dir=i_WB_Dir, o_WE_MEM_WB=i_WE. Stay in IDLE.
- IDLE, i_valid=1, load or store:
  - Latch addr, store data, WB_Dir, i_WE and the op type.
  - Set o_mem_req=1 and o_mem_we=i_mem_write.
  - Clear the timeout counter, register o_WE_MEM_WB=0, go to BUSY.
- BUSY:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are held constant.
  - o_WE_MEM_WB stays 0, and the counter increments every cycle.
- BUSY, i_mem_ack=1:
  - Drop o_mem_req and go to IDLE.
  - Load: o_WB_Data=i_mem_rdata, o_WB_Dir=latched dir, o_WE_MEM_WB=latched WE.
  - Store: o_WE_MEM_WB=0.
- BUSY, no ack, counter=TIMEOUT-1: drop o_mem_req, set o_mem_err, o_WE_MEM_WB=0, go to IDLE. The instruction is discarded.
- Ack and timeout in the same cycle: the ack wins.
- Ack while in IDLE: ignored.
- o_stall is combinational and equals (state==BUSY). While o_stall=1, upstream holds i_* stable and this block ignores them.
- Reset, including in the middle of an access:
  - State returns to IDLE; counter, o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata all go to 0.
  - o_WE_MEM_WB, o_WB_Data, o_WB_Dir and o_mem_err all go to 0.
  - These values appear immediately, without waiting for a clock edge.

## Timing
- Non-memory instruction sampled at edge k: its WB outputs are valid after edge k (1-cycle latency).
- Memory instruction sampled at edge k:
  - o_mem_req is high from edge k until the edge at which ack is sampled.
  - For an ack sampled at edge k+n (n≥1), WB outputs are valid after edge k+n and o_stall is high for n cycles.
- Minimum load latency is 2 edges (ack in the first BUSY cycle). The next instruction is accepted at edge k+n+1 at the earliest.
- Timeout abort happens at edge k+TIMEOUT.
- There is no combinational path from i_mem_ack to any memory-port output.

## Structure
- Shared package `proc_pkg` holds:
  - the `mem_state_t` enum {IDLE, BUSY};
  - DATA_W and DIR_W defaults;
  - counter width, defined as the constant CNT_W=8.
- One natural sub-module, `mem_timeout_ctr`:
  - behaviour: clear, enable, and an `expired` output when count==TIMEOUT-1;
  - same asynchronous reset as this block.

## Test plan
- Reset, then ALU op (i_alu_result=0x0000_00AA, i_WB_Dir=3, i_WE=1) → next cycle o_WB_Data=0xAA, o_WB_Dir=3, o_WE_MEM_WB=1, o_stall=0.
- Load at addr 0x40, ack on the 3rd BUSY cycle with rdata 0xDEAD_BEEF → o_stall high for 3 cycles with o_WE_MEM_WB=0 throughout; then o_WB_Data=0xDEADBEEF, o_WE_MEM_WB=1.
- Store addr 0x10 data 0x1234, immediate ack → one write request with o_mem_we=1 and o_mem_wdata=0x1234; o_WE_MEM_WB=0.
- Load with no ack, TIMEOUT=16 → o_mem_req drops at edge k+16, o_mem_err=1 and stays 1; the next ALU op completes normally.
- Load with ack arriving exactly on the expiry cycle → load completes and o_mem_err stays 0.
- rst pulsed mid-BUSY → o_mem_req, o_stall and all outputs go to 0 immediately; a stray ack in IDLE after reset has no effect.

Source files
------------

// File: rtl/proc_pkg.sv
// ---------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the filter processor pipeline: MEM-stage state
// encoding, default data/register-address widths, default access timeout and
// the width of the access timeout counter.
// ---------------------------------------------------------------------------
package proc_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_DIR_W   = 4;
  localparam int DEF_TIMEOUT = 16;

  // Wide enough for any TIMEOUT up to 255.
  localparam int CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  // Terminal count of the timeout counter for a given TIMEOUT.
  function automatic logic [CNT_W-1:0] timeout_last(input int timeout);
    return CNT_W'(timeout - 1);
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// ---------------------------------------------------------------------------
// mem_timeout_ctr
// Up-counter that measures how long a memory access has been outstanding.
// expired is high while the count sits at TIMEOUT-1.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   clear   in   synchronous clear to zero (has priority over enable)
//   enable  in   count up by one this cycle
//   expired out  count == TIMEOUT-1
// ---------------------------------------------------------------------------
module mem_timeout_ctr
  import proc_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = timeout_last(TIMEOUT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the filter processor. Non-memory instructions pass their ALU
// result straight to the MEM/WB register; loads and stores are issued on a
// req/ack data-memory port while upstream is stalled. An access that sees no
// ack within TIMEOUT cycles is abandoned and flagged on o_mem_err (sticky).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   i_valid                  instruction presented by EX/MEM
//   i_mem_read, i_mem_write  load / store
//   i_addr, i_store_data     memory address and store data
//   i_alu_result             result for non-memory instructions
//   i_WE, i_WB_Dir           register-file write enable and destination
//   o_stall                  hold upstream (high while an access is open)
//   o_mem_req/we/addr/wdata  data-memory request port (all registered)
//   i_mem_ack, i_mem_rdata   access completion and read data
//   o_WE_MEM_WB, o_WB_Data, o_WB_Dir  registered writeback to MEM/WB
//   o_mem_err                sticky access-timeout flag
// ---------------------------------------------------------------------------
module mem_access_stage
  import proc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int DIR_W   = DEF_DIR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_WE,
  input  logic [DIR_W-1:0]  i_WB_Dir,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [DATA_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_WE_MEM_WB,
  output logic [DATA_W-1:0] o_WB_Data,
  output logic [DIR_W-1:0]  o_WB_Dir,
  output logic              o_mem_err
);

  mem_state_t state, state_nxt;

  logic              mem_req_nxt, mem_we_nxt;
  logic [DATA_W-1:0] mem_addr_nxt, mem_wdata_nxt;
  logic [DIR_W-1:0]  lat_dir, lat_dir_nxt;
  logic              lat_we, lat_we_nxt;
  logic              lat_load, lat_load_nxt;
  logic              wb_we_nxt;
  logic [DATA_W-1:0] wb_data_nxt;
  logic [DIR_W-1:0]  wb_dir_nxt;
  logic              mem_err_nxt;
  logic              ctr_clear, ctr_en, ctr_expired;

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (ctr_clear),
    .enable  (ctr_en),
    .expired (ctr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    mem_req_nxt   = o_mem_req;
    mem_we_nxt    = o_mem_we;
    mem_addr_nxt  = o_mem_addr;
    mem_wdata_nxt = o_mem_wdata;
    lat_dir_nxt   = lat_dir;
    lat_we_nxt    = lat_we;
    lat_load_nxt  = lat_load;
    wb_we_nxt     = 1'b0;
    wb_data_nxt   = o_WB_Data;
    wb_dir_nxt    = o_WB_Dir;
    mem_err_nxt   = o_mem_err;
    ctr_clear     = 1'b0;
    ctr_en        = 1'b0;

    case (state)
      IDLE: begin
        if (i_valid) begin
          if (i_mem_read || i_mem_write) begin
            mem_req_nxt   = 1'b1;
            mem_we_nxt    = i_mem_write;
            mem_addr_nxt  = i_addr;
            mem_wdata_nxt = i_store_data;
            lat_dir_nxt   = i_WB_Dir;
            lat_we_nxt    = i_WE;
            // The illegal read+write combination behaves as a store, so it
            // never writes the register file with undefined data.
            lat_load_nxt  = i_mem_read & ~i_mem_write;
            ctr_clear     = 1'b1;
            state_nxt     = BUSY;
          end else begin
            wb_data_nxt = i_alu_result;
            wb_dir_nxt  = i_WB_Dir;
            wb_we_nxt   = i_WE;
          end
        end
      end
      BUSY: begin
        ctr_en = 1'b1;
        // Ack is checked first so a completion on the expiry cycle wins.
        if (i_mem_ack) begin
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
          if (lat_load) begin
            wb_data_nxt = i_mem_rdata;
            wb_dir_nxt  = lat_dir;
            wb_we_nxt   = lat_we;
          end
        end else if (ctr_expired) begin
          mem_req_nxt = 1'b0;
          mem_err_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      lat_dir     <= '0;
      lat_we      <= 1'b0;
      lat_load    <= 1'b0;
      o_WE_MEM_WB <= 1'b0;
      o_WB_Data   <= '0;
      o_WB_Dir    <= '0;
      o_mem_err   <= 1'b0;
    end else begin
      o_mem_req   <= mem_req_nxt;
      o_mem_we    <= mem_we_nxt;
      o_mem_addr  <= mem_addr_nxt;
      o_mem_wdata <= mem_wdata_nxt;
      lat_dir     <= lat_dir_nxt;
      lat_we      <= lat_we_nxt;
      lat_load    <= lat_load_nxt;
      o_WE_MEM_WB <= wb_we_nxt;
      o_WB_Data   <= wb_data_nxt;
      o_WB_Dir    <= wb_dir_nxt;
      o_mem_err   <= mem_err_nxt;
    end
  end

  assign o_stall = (state == BUSY);

endmodule
